// File: rtl/operand_fetch_stage.sv
// ID-to-EX operand fetch stage for the 16-bit pipeline.
// Drives the register file read ports and resolves each source operand by
// forwarding from EX (non-load results) and WB. A load-use hazard becomes a
// one-cycle bubble. The resolved operands and the control bundle are held in
// the ID/EX latch, which uses a valid/ready handshake.
module operand_fetch_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    // decoder side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [CTRL_W-1:0] in_ctrl,
    // register file read ports
    output logic [4:0]        rR1_addr,
    output logic [4:0]        rR2_addr,
    output logic              rR1_en,
    output logic              rR2_en,
    input  logic [15:0]       R1_data,
    input  logic [15:0]       R2_data,
    // forwarding sources
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_wr_addr,
    input  logic [15:0]       ex_result,
    input  logic              wb_wr_en,
    input  logic [4:0]        wb_wr_addr,
    input  logic [15:0]       wb_data,
    // pipeline kill
    input  logic              flush,
    // EX side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       op_a,
    output logic [15:0]       op_b,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    logic              w_hazard;
    logic              w_load;
    logic [15:0]       w_op_a;
    logic [15:0]       w_op_b;

    logic              r_out_valid;
    logic [15:0]       r_op_a;
    logic [15:0]       r_op_b;
    logic [4:0]        r_out_rd;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [CNT_W-1:0]  r_stall_count;

    // The register file is read directly with the decoded source fields.
    assign rR1_addr = in_rs1;
    assign rR2_addr = in_rs2;
    assign rR1_en   = in_valid & in_use_rs1;
    assign rR2_en   = in_valid & in_use_rs2;

    // Resolve source 1: unused -> zero, then EX (non-load), then WB, then the file.
    always_comb begin
        // NOTE: assign a default first so that a path with no assignment cannot infer a latch.
        w_op_a = 16'h0000;
        if (!in_use_rs1)
            w_op_a = 16'h0000;
        else if (ex_wr_en && !ex_is_load && (ex_wr_addr == in_rs1))
            w_op_a = ex_result;
        else if (wb_wr_en && (wb_wr_addr == in_rs1))
            w_op_a = wb_data;
        else
            w_op_a = R1_data;
    end

    // Resolve source 2 with the same priority as source 1.
    always_comb begin
        w_op_b = 16'h0000;
        if (!in_use_rs2)
            w_op_b = 16'h0000;
        else if (ex_wr_en && !ex_is_load && (ex_wr_addr == in_rs2))
            w_op_b = ex_result;
        else if (wb_wr_en && (wb_wr_addr == in_rs2))
            w_op_b = wb_data;
        else
            w_op_b = R2_data;
    end

    // A load in EX has no data yet, so a consumer of its destination must wait one cycle.
    assign w_hazard = in_valid & ex_wr_en & ex_is_load &
                      ((in_use_rs1 & (ex_wr_addr == in_rs1)) |
                       (in_use_rs2 & (ex_wr_addr == in_rs2)));
    assign w_load   = ~r_out_valid | out_ready;
    // A flush consumes and discards the offered instruction, even during a hazard.
    assign in_ready = flush | (w_load & ~w_hazard);

    // ID/EX latch: flush kills, accept captures, hazard bubbles, otherwise drain or hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid   <= 1'b0;
            r_op_a        <= 16'h0000;
            r_op_b        <= 16'h0000;
            r_out_rd      <= 5'd0;
            r_out_ctrl    <= '0;
            r_stall_count <= '0;
        end else if (flush) begin
            // NOTE: non-blocking assignments let every register sample pre-edge values.
            r_out_valid <= 1'b0;
        end else if (w_load && in_valid && !w_hazard) begin
            r_out_valid <= 1'b1;
            r_op_a      <= w_op_a;
            r_op_b      <= w_op_b;
            r_out_rd    <= in_rd;
            r_out_ctrl  <= in_ctrl;
        end else if (w_load && w_hazard) begin
            r_out_valid <= 1'b0;
            if (r_stall_count != {CNT_W{1'b1}})
                r_stall_count <= r_stall_count + CNT_W'(1);
        end else if (w_load) begin
            r_out_valid <= 1'b0;
        end
        // EX stalled: every register holds its value. Held operands are not re-forwarded.
    end

    assign out_valid   = r_out_valid;
    assign op_a        = r_op_a;
    assign op_b        = r_op_b;
    assign out_rd      = r_out_rd;
    assign out_ctrl    = r_out_ctrl;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage. Directed scenarios are followed
// by randomized traffic. Expected values come from a transaction-level model.
// A second instance with a 2-bit counter exercises stall counter saturation.
module tb_operand_fetch_stage;

    localparam int CTRL_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              in_valid, in_use_rs1, in_use_rs2;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic [CTRL_W-1:0] in_ctrl;
    logic              ex_wr_en, ex_is_load, wb_wr_en, flush, out_ready;
    logic [4:0]        ex_wr_addr, wb_wr_addr;
    logic [15:0]       ex_result, wb_data;

    wire               in_ready, rR1_en, rR2_en, out_valid;
    wire  [4:0]        rR1_addr, rR2_addr, out_rd;
    wire  [15:0]       op_a, op_b;
    wire  [CTRL_W-1:0] out_ctrl;
    wire  [15:0]       stall_count;

    wire               in_ready_s, rR1_en_s, rR2_en_s, out_valid_s;
    wire  [4:0]        rR1_addr_s, rR2_addr_s, out_rd_s;
    wire  [15:0]       op_a_s, op_b_s;
    wire  [CTRL_W-1:0] out_ctrl_s;
    wire  [1:0]        stall_count_s;

    // Register file model: the data bus floats whenever the read enable is low.
    logic [15:0] rf [32];
    wire  [15:0] R1_data = rR1_en ? rf[rR1_addr] : 16'hzzzz;
    wire  [15:0] R2_data = rR2_en ? rf[rR2_addr] : 16'hzzzz;

    operand_fetch_stage #(.CTRL_W(CTRL_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_ctrl(in_ctrl),
        .rR1_addr(rR1_addr), .rR2_addr(rR2_addr), .rR1_en(rR1_en), .rR2_en(rR2_en),
        .R1_data(R1_data), .R2_data(R2_data),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
        .ex_result(ex_result),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .out_rd(out_rd), .out_ctrl(out_ctrl),
        .stall_count(stall_count)
    );

    operand_fetch_stage #(.CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_ctrl(in_ctrl),
        .rR1_addr(rR1_addr_s), .rR2_addr(rR2_addr_s), .rR1_en(rR1_en_s), .rR2_en(rR2_en_s),
        .R1_data(R1_data), .R2_data(R2_data),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
        .ex_result(ex_result),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .op_a(op_a_s), .op_b(op_b_s), .out_rd(out_rd_s), .out_ctrl(out_ctrl_s),
        .stall_count(stall_count_s)
    );

    wire [63:0] dut_outs = {out_valid, op_a, op_b, out_rd, out_ctrl, stall_count, stall_count_s};

    int checks   = 0;
    int failures = 0;

    // Transaction-level model of the ID/EX latch contents.
    logic              m_valid;
    logic [15:0]       m_a, m_b;
    logic [4:0]        m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    int                m_cnt, m_cnt_s;

    function automatic logic [63:0] model_outs();
        logic [15:0] c16;
        logic [1:0]  c2;
        c16 = m_cnt[15:0];
        c2  = m_cnt_s[1:0];
        return {m_valid, m_a, m_b, m_rd, m_ctrl, c16, c2};
    endfunction

    // The operand value the instruction architecturally sees.
    function automatic logic [15:0] resolve(logic use_x, logic [4:0] rs);
        if (!use_x) return 16'h0000;
        if (ex_wr_en && !ex_is_load && ex_wr_addr == rs) return ex_result;
        if (wb_wr_en && wb_wr_addr == rs) return wb_data;
        return rf[rs];
    endfunction

    function automatic logic model_hazard();
        return in_valid && ex_wr_en && ex_is_load &&
               ((in_use_rs1 && ex_wr_addr == in_rs1) || (in_use_rs2 && ex_wr_addr == in_rs2));
    endfunction

    function automatic logic model_ready();
        return flush || ((!m_valid || out_ready) && !model_hazard());
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_a = '0; m_b = '0; m_rd = '0; m_ctrl = '0;
        m_cnt = 0; m_cnt_s = 0;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_use_rs1 = 0; in_use_rs2 = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_ctrl = 0;
        ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_result = 0;
        wb_wr_en = 0; wb_wr_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    // One clock: predict the latch update from the current inputs, then let the edge pass.
    task automatic advance();
        logic hz, ld, wb_en;
        logic [15:0] a, b, wd;
        logic [4:0] wa;
        hz = model_hazard();
        ld = !m_valid || out_ready;
        a  = resolve(in_use_rs1, in_rs1);
        b  = resolve(in_use_rs2, in_rs2);
        wb_en = wb_wr_en; wa = wb_wr_addr; wd = wb_data;
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
        end else if (ld && in_valid && !hz) begin
            m_valid = 1'b1; m_a = a; m_b = b; m_rd = in_rd; m_ctrl = in_ctrl;
        end else if (ld && hz) begin
            m_valid = 1'b0;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
        end else if (ld) begin
            m_valid = 1'b0;
        end
        #1;
        if (wb_en) rf[wa] = wd;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        checks++;
        if (dut_outs !== 64'h0)
            begin failures++; $display("FAIL reset_initial got=%h exp=%h", dut_outs, 64'h0); end
        #11 reset = 1'b1;
        rf[9] = 16'h1234;
        in_valid = 1; in_use_rs1 = 1; in_rs1 = 9; in_rd = 5'd4; in_ctrl = 8'h5C;
        advance();
        checks++;
        if (out_valid !== 1'b1 || op_a !== 16'h1234)
            begin failures++; $display("FAIL reset_preload got valid=%b op_a=%h exp 1/1234", out_valid, op_a); end
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_outs !== 64'h0)
            begin failures++; $display("FAIL reset_async got=%h exp=%h", dut_outs, 64'h0); end
        #2 reset = 1'b1;
        idle_inputs();
    endtask

    task automatic test_ex_forward();
        rf[5] = 16'h0001;
        in_valid = 1; in_use_rs1 = 1; in_rs1 = 5; in_use_rs2 = 0; in_rd = 5'd6; in_ctrl = 8'hA1;
        ex_wr_en = 1; ex_wr_addr = 5; ex_result = 16'hBEEF;
        advance();
        checks++;
        if (op_a !== 16'hBEEF || out_valid !== 1'b1)
            begin failures++; $display("FAIL ex_forward got op_a=%h valid=%b exp BEEF/1", op_a, out_valid); end
        checks++;
        if (dut_outs !== model_outs())
            begin failures++; $display("FAIL ex_forward_model got=%h exp=%h", dut_outs, model_outs()); end
    endtask

    task automatic test_ex_beats_wb();
        idle_inputs();
        in_valid = 1; in_use_rs1 = 0; in_rs1 = 12; in_use_rs2 = 1; in_rs2 = 7; in_rd = 5'd2; in_ctrl = 8'h3C;
        ex_wr_en = 1; ex_wr_addr = 7; ex_result = 16'h2222;
        wb_wr_en = 1; wb_wr_addr = 7; wb_data = 16'h3333;
        #1;
        checks++;
        if (rR1_en !== 1'b0 || rR2_en !== 1'b1 || rR2_addr !== 5'd7)
            begin failures++; $display("FAIL read_ports got en1=%b en2=%b addr2=%0d exp 0/1/7", rR1_en, rR2_en, rR2_addr); end
        advance();
        checks++;
        if (op_b !== 16'h2222 || op_a !== 16'h0000)
            begin failures++; $display("FAIL ex_beats_wb got op_a=%h op_b=%h exp 0000/2222", op_a, op_b); end
        checks++;
        if (dut_outs !== model_outs())
            begin failures++; $display("FAIL ex_beats_wb_model got=%h exp=%h", dut_outs, model_outs()); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        in_valid = 1; in_use_rs1 = 1; in_rs1 = 3; in_rd = 5'd8; in_ctrl = 8'h11;
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 3;
        #1;
        checks++;
        if (in_ready !== 1'b0)
            begin failures++; $display("FAIL load_use_ready got=%b exp=0", in_ready); end
        advance();
        checks++;
        if (out_valid !== 1'b0 || stall_count !== 16'd1)
            begin failures++; $display("FAIL load_use_bubble got valid=%b cnt=%0d exp 0/1", out_valid, stall_count); end
        ex_wr_en = 0; ex_is_load = 0;
        wb_wr_en = 1; wb_wr_addr = 3; wb_data = 16'h00AA;
        #1;
        checks++;
        if (in_ready !== 1'b1)
            begin failures++; $display("FAIL load_use_release got=%b exp=1", in_ready); end
        advance();
        checks++;
        if (op_a !== 16'h00AA || out_valid !== 1'b1)
            begin failures++; $display("FAIL load_use_wb_fwd got op_a=%h valid=%b exp 00AA/1", op_a, out_valid); end
        checks++;
        if (dut_outs !== model_outs())
            begin failures++; $display("FAIL load_use_model got=%h exp=%h", dut_outs, model_outs()); end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        rf[10] = 16'h5A5A;
        out_ready = 0;
        in_valid = 1; in_use_rs1 = 1; in_rs1 = 10; in_use_rs2 = 1; in_rs2 = 10; in_rd = 5'd13; in_ctrl = 8'hE7;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0)
                begin failures++; $display("FAIL bp_ready cycle=%0d got=%b exp=0", i, in_ready); end
            advance();
            checks++;
            if (op_a !== 16'h00AA || out_rd !== 5'd8 || out_ctrl !== 8'h11 || out_valid !== 1'b1)
                begin failures++; $display("FAIL bp_hold cycle=%0d got op_a=%h rd=%0d ctrl=%h v=%b exp 00AA/8/11/1", i, op_a, out_rd, out_ctrl, out_valid); end
            checks++;
            if (dut_outs !== model_outs())
                begin failures++; $display("FAIL bp_model cycle=%0d got=%h exp=%h", i, dut_outs, model_outs()); end
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1)
            begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        advance();
        checks++;
        if (op_a !== 16'h5A5A || op_b !== 16'h5A5A || out_rd !== 5'd13 || out_ctrl !== 8'hE7)
            begin failures++; $display("FAIL bp_release got op_a=%h op_b=%h rd=%0d ctrl=%h", op_a, op_b, out_rd, out_ctrl); end
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 1; in_use_rs1 = 1; in_rs1 = 4; in_rd = 5'd1;
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 4;
        flush = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1)
            begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        advance();
        checks++;
        if (out_valid !== 1'b0 || stall_count !== 16'd1 || op_a !== 16'h5A5A)
            begin failures++; $display("FAIL flush_kill got v=%b cnt=%0d op_a=%h exp 0/1/5A5A", out_valid, stall_count, op_a); end
        flush = 0;
    endtask

    task automatic test_saturation();
        idle_inputs();
        in_valid = 1; in_use_rs2 = 1; in_rs2 = 20;
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 20;
        for (int i = 0; i < 4; i++) begin
            advance();
            checks++;
            if (dut_outs !== model_outs())
                begin failures++; $display("FAIL sat_model bubble=%0d got=%h exp=%h", i, dut_outs, model_outs()); end
        end
        checks++;
        if (stall_count_s !== 2'd3 || stall_count !== 16'd5)
            begin failures++; $display("FAIL saturation got small=%0d wide=%0d exp 3/5", stall_count_s, stall_count); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic held;
        for (int n = 0; n < 400; n++) begin
            held = in_valid && !model_ready();
            if (!held) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                in_use_rs1 = $urandom_range(0, 1);
                in_use_rs2 = $urandom_range(0, 1);
                in_rs1     = 5'($urandom_range(0, 3));
                in_rs2     = 5'($urandom_range(0, 3));
                in_rd      = 5'($urandom_range(0, 31));
                in_ctrl    = 8'($urandom);
            end
            ex_wr_en   = $urandom_range(0, 1);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_wr_addr = 5'($urandom_range(0, 3));
            ex_result  = 16'($urandom);
            wb_wr_en   = $urandom_range(0, 1);
            wb_wr_addr = 5'($urandom_range(0, 3));
            wb_data    = 16'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== model_ready() || rR1_en !== (in_valid & in_use_rs1) || rR1_addr !== in_rs1 ||
                rR2_en !== (in_valid & in_use_rs2) || rR2_addr !== in_rs2)
                begin failures++; $display("FAIL rand_comb n=%0d got ready=%b exp=%b", n, in_ready, model_ready()); end
            advance();
            checks++;
            if (dut_outs !== model_outs())
                begin failures++; $display("FAIL rand_latch n=%0d got=%h exp=%h", n, dut_outs, model_outs()); end
        end
        idle_inputs();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 16'($urandom);
        test_reset();
        test_ex_forward();
        test_ex_beats_wb();
        test_load_use();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- ID-to-EX stage of the 16-bit pipeline.
- Takes decoded register fields from the decoder and drives the read ports of the 32x16 register file.
- Resolves RAW hazards by forwarding from EX and WB, and inserts a bubble on load-use hazards.
- Registers operands and control into the ID/EX pipeline latch with a valid/ready handshake.
- Keeps a saturating count of hazard bubbles.

Parameters:
- CTRL_W, 8, width of the opaque control bundle passed through to EX.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- in_valid  input  1  decoder offers an instruction.
- in_ready  output  1  stage accepts the offered instruction this cycle.
- in_rs1, in_rs2, in_rd  input  5 each  source and destination register addresses.
- in_use_rs1, in_use_rs2  input  1 each  instruction reads rs1 / rs2.
- in_ctrl  input  CTRL_W  control bundle.
- rR1_addr, rR2_addr  output  5 each  register file read addresses (= in_rs1, in_rs2).
- rR1_en, rR2_en  output  1 each  register file read enables.
- R1_data, R2_data  input  16 each  register file read data (high-Z when the enable is low).
- ex_wr_en, ex_is_load  input  1 each  EX-stage instruction writes a register / is a load.
- ex_wr_addr  input  5  EX-stage destination register.
- ex_result  input  16  EX-stage ALU result.
- wb_wr_en  input  1  WB-stage write enable (same net as the register file write_en).
- wb_wr_addr  input  5  WB-stage destination register.
- wb_data  input  16  WB-stage write data.
- flush  input  1  synchronous pipeline kill (branch taken).
- out_valid  output  1  ID/EX latch holds a valid instruction.
- out_ready  input  1  EX accepts the latch contents.
- op_a, op_b  output  16 each  resolved operands.
- out_rd  output  5  destination register.
- out_ctrl  output  CTRL_W  control bundle.
- stall_count  output  CNT_W  number of load-use bubbles inserted.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0; op_a, op_b, out_rd, out_ctrl and stall_count are all 0. Registers release on the first rising edge after reset returns to 1.
- Read ports (combinational): rRx_addr = in_rsx; rRx_en = in_valid & in_use_rsx.
- Register 0 is an ordinary register: no hard-wired zero and no forwarding exclusion.
- Operand resolution, per source x (combinational), first match wins:
  - in_use_rsx=0 -> 0x0000. A high-Z bus is never latched.
  - ex_wr_en & ~ex_is_load & ex_wr_addr==in_rsx -> ex_result.
  - wb_wr_en & wb_wr_addr==in_rsx -> wb_data. This bypasses the register file, whose write completes only at the clock edge.
  - Otherwise -> R1_data / R2_data.
- Load-use hazard: hazard = in_valid & ex_wr_en & ex_is_load & ((in_use_rs1 & ex_wr_addr==in_rs1) | (in_use_rs2 & ex_wr_addr==in_rs2)).
- Latch load enable: load = ~out_valid | out_ready.
- in_ready = flush | (load & ~hazard).
- Each rising edge, in priority order:
  - flush=1: out_valid<=0. The offered instruction is consumed and discarded. Data registers hold. stall_count is unchanged.
  - else load & in_valid & ~hazard: capture the resolved operands, in_rd and in_ctrl; out_valid<=1.
  - else load & hazard: out_valid<=0 (bubble); stall_count<=stall_count+1, saturating at all-ones.
  - else load: out_valid<=0.
  - else (EX stalled): hold all outputs. Forwarding is not re-evaluated for held contents.
- Latency: one cycle from acceptance to out_valid.
- Throughput: one instruction per cycle with no hazards.
- A load-use hazard costs exactly one bubble, because the load then moves to WB and is forwarded from there.
- A hazard while EX is stalled produces no bubble and no count increment.
- in_valid with in_ready=0: the decoder must hold in_* stable. The stage re-evaluates each cycle.

Test Plan:
- Reset mid-stream: out_valid=1, op_a=0x1234, then reset=0 asynchronously -> all outputs 0 immediately, without waiting for a clock edge.
- EX forwarding: R5 holds 0x0001 in the file, ex_wr_en=1, ex_wr_addr=5, ex_result=0xBEEF, in_rs1=5 -> next cycle op_a=0xBEEF.
- EX beats WB: ex_result=0x2222 and wb_data=0x3333, both targeting R7, in_rs2=7 -> op_b=0x2222. Unused rs1 (in_use_rs1=0) -> op_a=0x0000 and rR1_en=0.
- Load-use: ex_is_load=1, ex_wr_addr=3, consumer reads R3 -> in_ready=0 for one cycle, one bubble (out_valid=0), stall_count 0->1. Next cycle wb_data=0x00AA forwarded -> op_a=0x00AA.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> op_a, op_b, out_rd, out_ctrl held and in_ready=0. Release -> next instruction latched on the following edge.
- Flush and saturation: flush=1 while in_valid=1 -> in_ready=1 and out_valid=0 next cycle. With CNT_W=2, four load-use bubbles -> stall_count stays at 3.
